// File: rtl/ifetch_data_stage_pkg.sv
// Shared L1 instruction cache geometry, address/line types and fetch fault codes.
// Imported by the instruction fetch data stage and its bench.
package ifetch_data_stage_pkg;

    localparam int THREADS_PER_CORE         = 4;
    localparam int L1I_WAYS                 = 4;
    localparam int L1I_SETS                 = 64;
    localparam int CACHE_LINE_BYTES         = 64;
    localparam int CACHE_LINE_BITS          = CACHE_LINE_BYTES * 8;
    localparam int CACHE_LINE_WORDS         = CACHE_LINE_BYTES / 4;
    localparam int CACHE_LINE_OFFSET_WIDTH  = $clog2(CACHE_LINE_BYTES);
    localparam int L1I_SET_IDX_WIDTH        = $clog2(L1I_SETS);
    localparam int L1I_WAY_IDX_WIDTH        = $clog2(L1I_WAYS);
    localparam int L1I_TAG_WIDTH            = 32 - L1I_SET_IDX_WIDTH - CACHE_LINE_OFFSET_WIDTH;

    typedef logic [$clog2(THREADS_PER_CORE)-1:0]            local_thread_idx_t;
    typedef logic [L1I_TAG_WIDTH-1:0]                       l1i_tag_t;
    typedef logic [L1I_SET_IDX_WIDTH-1:0]                   l1i_set_idx_t;
    typedef logic [L1I_WAY_IDX_WIDTH-1:0]                   l1i_way_idx_t;
    typedef logic [CACHE_LINE_BITS-1:0]                     cache_line_data_t;
    typedef logic [L1I_TAG_WIDTH+L1I_SET_IDX_WIDTH-1:0]     cache_line_index_t;

    typedef struct packed {
        l1i_tag_t                             tag;
        l1i_set_idx_t                         set_idx;
        logic [CACHE_LINE_OFFSET_WIDTH-1:0]   offset;
    } l1i_addr_t;

    typedef enum logic [2:0] {
        FAULT_NONE,
        FAULT_ALIGNMENT,
        FAULT_TLB_MISS,
        FAULT_PAGE,
        FAULT_SUPERVISOR,
        FAULT_EXECUTABLE
    } ifetch_fault_t;

    // Highest-priority fault only; lower faults are masked by earlier ones.
    function automatic ifetch_fault_t classify_fault(
        input logic [1:0] vaddr_low,
        input logic       tlb_hit,
        input logic       tlb_present,
        input logic       tlb_supervisor,
        input logic       supervisor_mode,
        input logic       tlb_executable
    );
        if (vaddr_low != 2'b00)
            return FAULT_ALIGNMENT;
        else if (!tlb_hit)
            return FAULT_TLB_MISS;
        else if (!tlb_present)
            return FAULT_PAGE;
        else if (tlb_supervisor && !supervisor_mode)
            return FAULT_SUPERVISOR;
        else if (!tlb_executable)
            return FAULT_EXECUTABLE;
        else
            return FAULT_NONE;
    endfunction

endpackage

// File: rtl/ifetch_data_stage_sram.sv
// One-cycle-latency 1R1W storage and one-hot to binary encoder used by the fetch data stage.
module sram_1r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 64,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  read_en_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i
);
    logic [DATA_WIDTH-1:0] mem_q [SIZE];
    logic [DATA_WIDTH-1:0] read_data_q;

    always_ff @(posedge clk) begin
        if (write_en_i)
            mem_q[write_addr_i] <= write_data_i;
        // A fill landing on the line being read forwards the new data.
        if (read_en_i) begin
            if (write_en_i && write_addr_i == read_addr_i)
                read_data_q <= write_data_i;
            else
                read_data_q <= mem_q[read_addr_i];
        end
    end

    assign read_data_o = read_data_q;
endmodule

module oh_to_idx #(
    parameter int NUM_SIGNALS = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic [NUM_SIGNALS-1:0] one_hot_i,
    output logic [INDEX_WIDTH-1:0] index_o
);
    always_comb begin
        index_o = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot_i[i])
                index_o = index_o | INDEX_WIDTH'(i);
        end
    end
endmodule

// File: rtl/ifetch_data_stage.sv
// Instruction fetch data stage: tag compare, fault check, miss/near-miss report and
// one-cycle line read that delivers the selected instruction word to decode.
module ifetch_data_stage
    import ifetch_data_stage_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              ift_instruction_requested,
    input  l1i_addr_t                         ift_pc_paddr,
    input  logic [31:0]                       ift_pc_vaddr,
    input  local_thread_idx_t                 ift_thread_idx,
    input  logic                              ift_tlb_hit,
    input  logic                              ift_tlb_present,
    input  logic                              ift_tlb_executable,
    input  logic                              ift_tlb_supervisor,
    input  l1i_tag_t                          ift_tag [L1I_WAYS],
    input  logic [L1I_WAYS-1:0]               ift_valid,

    input  logic                              l2i_idata_update_en,
    input  l1i_way_idx_t                      l2i_idata_update_way,
    input  l1i_set_idx_t                      l2i_idata_update_set,
    input  cache_line_data_t                  l2i_idata_update_data,
    input  logic [L1I_WAYS-1:0]               l2i_itag_update_en,
    input  l1i_set_idx_t                      l2i_itag_update_set,
    input  l1i_tag_t                          l2i_itag_update_tag,
    input  logic                              l2i_itag_update_valid,

    input  logic [THREADS_PER_CORE-1:0]       cr_supervisor_en,
    input  logic                              wb_rollback_en,
    input  local_thread_idx_t                 wb_rollback_thread_idx,

    output logic                              ifd_update_lru_en,
    output l1i_way_idx_t                      ifd_update_lru_way,
    output logic                              ifd_cache_miss,
    output logic                              ifd_near_miss,
    output cache_line_index_t                 ifd_cache_miss_paddr,
    output local_thread_idx_t                 ifd_cache_miss_thread_idx,

    output logic                              ifd_instruction_valid,
    output logic [31:0]                       ifd_instruction,
    output logic [31:0]                       ifd_pc,
    output local_thread_idx_t                 ifd_thread_idx,
    output logic                              ifd_alignment_fault,
    output logic                              ifd_tlb_miss,
    output logic                              ifd_page_fault,
    output logic                              ifd_supervisor_fault,
    output logic                              ifd_executable_fault
);
    localparam int WORD_IDX_WIDTH = $clog2(CACHE_LINE_WORDS);

    logic [L1I_WAYS-1:0]        hit_oh;
    logic                       hit;
    l1i_way_idx_t               hit_way;
    ifetch_fault_t              fault;
    logic                       has_fault;
    logic                       fetch_hit;
    logic                       near_miss;
    logic                       rollback_this;
    cache_line_data_t           line_data;

    logic                       valid_d, valid_q;
    ifetch_fault_t              fault_d, fault_q;
    logic                       hit_d, hit_q;
    logic [WORD_IDX_WIDTH-1:0]  word_idx_d, word_idx_q;
    logic [31:0]                pc_d, pc_q;
    local_thread_idx_t          thread_d, thread_q;

    always_comb begin
        hit_oh = '0;
        for (int w = 0; w < L1I_WAYS; w++)
            hit_oh[w] = ift_valid[w] && (ift_tag[w] == ift_pc_paddr.tag);
    end

    assign hit = |hit_oh;

    oh_to_idx #(
        .NUM_SIGNALS(L1I_WAYS)
    ) u_hit_enc (
        .one_hot_i (hit_oh),
        .index_o   (hit_way)
    );

    assign fault = classify_fault(ift_pc_vaddr[1:0], ift_tlb_hit, ift_tlb_present,
                                  ift_tlb_supervisor, cr_supervisor_en[ift_thread_idx],
                                  ift_tlb_executable);
    assign has_fault = (fault != FAULT_NONE);
    assign fetch_hit = ift_instruction_requested && hit && !has_fault;

    // A tag fill for this exact line is landing now: the fetch must retry, not re-request.
    assign near_miss = ift_instruction_requested && !hit && !has_fault
                       && (|l2i_itag_update_en)
                       && (l2i_itag_update_set == ift_pc_paddr.set_idx)
                       && (l2i_itag_update_tag == ift_pc_paddr.tag)
                       && l2i_itag_update_valid;

    assign ifd_cache_miss            = ift_instruction_requested && !hit && !has_fault && !near_miss;
    assign ifd_near_miss             = near_miss;
    assign ifd_cache_miss_paddr      = {ift_pc_paddr.tag, ift_pc_paddr.set_idx};
    assign ifd_cache_miss_thread_idx = ift_thread_idx;
    assign ifd_update_lru_en         = fetch_hit;
    assign ifd_update_lru_way        = hit_way;

    assign rollback_this = wb_rollback_en && (wb_rollback_thread_idx == ift_thread_idx);

    sram_1r1w #(
        .DATA_WIDTH (CACHE_LINE_BITS),
        .SIZE       (L1I_WAYS * L1I_SETS)
    ) u_data_array (
        .clk          (clk),
        .read_en_i    (fetch_hit),
        .read_addr_i  ({hit_way, ift_pc_paddr.set_idx}),
        .read_data_o  (line_data),
        .write_en_i   (l2i_idata_update_en),
        .write_addr_i ({l2i_idata_update_way, l2i_idata_update_set}),
        .write_data_i (l2i_idata_update_data)
    );

    always_comb begin
        valid_d    = ift_instruction_requested && (hit || has_fault) && !rollback_this;
        fault_d    = ift_instruction_requested ? fault : FAULT_NONE;
        hit_d      = fetch_hit;
        word_idx_d = ift_pc_paddr.offset[CACHE_LINE_OFFSET_WIDTH-1:2];
        pc_d       = ift_pc_vaddr;
        thread_d   = ift_thread_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            fault_q    <= FAULT_NONE;
            hit_q      <= 1'b0;
            word_idx_q <= '0;
            pc_q       <= '0;
            thread_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            hit_q      <= hit_d;
            word_idx_q <= word_idx_d;
            pc_q       <= pc_d;
            thread_q   <= thread_d;
        end
    end

    // Word 0 sits in the top bits, so the bit base is (WORDS-1-idx)*32 == ~idx*32.
    assign ifd_instruction       = hit_q ? line_data[{~word_idx_q, 5'b00000} +: 32] : 32'h0;
    assign ifd_instruction_valid = valid_q;
    assign ifd_pc                = pc_q;
    assign ifd_thread_idx        = thread_q;
    assign ifd_alignment_fault   = (fault_q == FAULT_ALIGNMENT);
    assign ifd_tlb_miss          = (fault_q == FAULT_TLB_MISS);
    assign ifd_page_fault        = (fault_q == FAULT_PAGE);
    assign ifd_supervisor_fault  = (fault_q == FAULT_SUPERVISOR);
    assign ifd_executable_fault  = (fault_q == FAULT_EXECUTABLE);

    always_ff @(posedge clk) begin
        if (reset && ift_instruction_requested)
            assert ($onehot0(hit_oh)) else $error("ifetch_data_stage: multiple ways hit");
    end
endmodule

// File: tb/tb_ifetch_data_stage.sv
// Bench for ifetch_data_stage: directed scenarios plus randomized fetches against a line-level model.
module tb_ifetch_data_stage;
    import ifetch_data_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                         req;
    l1i_addr_t                    paddr;
    logic [31:0]                  vaddr;
    local_thread_idx_t            tid;
    logic                         tlb_hit, tlb_present, tlb_exec, tlb_sup;
    l1i_tag_t                     tags [L1I_WAYS];
    logic [L1I_WAYS-1:0]          valids;
    logic                         id_en;
    l1i_way_idx_t                 id_way;
    l1i_set_idx_t                 id_set;
    cache_line_data_t             id_data;
    logic [L1I_WAYS-1:0]          it_en;
    l1i_set_idx_t                 it_set;
    l1i_tag_t                     it_tag;
    logic                         it_valid;
    logic [THREADS_PER_CORE-1:0]  sup_en;
    logic                         rb_en;
    local_thread_idx_t            rb_tid;

    logic                         lru_en, miss, nmiss, ivalid;
    l1i_way_idx_t                 lru_way;
    cache_line_index_t            miss_paddr;
    local_thread_idx_t            miss_tid, otid;
    logic [31:0]                  instr, opc;
    logic                         f_al, f_tlb, f_pg, f_sup, f_ex;

    ifetch_data_stage dut (
        .clk(clk), .reset(reset),
        .ift_instruction_requested(req), .ift_pc_paddr(paddr), .ift_pc_vaddr(vaddr),
        .ift_thread_idx(tid), .ift_tlb_hit(tlb_hit), .ift_tlb_present(tlb_present),
        .ift_tlb_executable(tlb_exec), .ift_tlb_supervisor(tlb_sup),
        .ift_tag(tags), .ift_valid(valids),
        .l2i_idata_update_en(id_en), .l2i_idata_update_way(id_way),
        .l2i_idata_update_set(id_set), .l2i_idata_update_data(id_data),
        .l2i_itag_update_en(it_en), .l2i_itag_update_set(it_set),
        .l2i_itag_update_tag(it_tag), .l2i_itag_update_valid(it_valid),
        .cr_supervisor_en(sup_en), .wb_rollback_en(rb_en), .wb_rollback_thread_idx(rb_tid),
        .ifd_update_lru_en(lru_en), .ifd_update_lru_way(lru_way),
        .ifd_cache_miss(miss), .ifd_near_miss(nmiss),
        .ifd_cache_miss_paddr(miss_paddr), .ifd_cache_miss_thread_idx(miss_tid),
        .ifd_instruction_valid(ivalid), .ifd_instruction(instr), .ifd_pc(opc),
        .ifd_thread_idx(otid), .ifd_alignment_fault(f_al), .ifd_tlb_miss(f_tlb),
        .ifd_page_fault(f_pg), .ifd_supervisor_fault(f_sup), .ifd_executable_fault(f_ex)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: line contents per (way,set) plus expected outputs for the current inputs.
    cache_line_data_t mem_m [L1I_WAYS][L1I_SETS];
    logic        e_lru_en, e_miss, e_nmiss, e_valid;
    int          e_way;
    logic [4:0]  e_flags;
    logic [31:0] e_instr;

    function automatic logic [31:0] word_of(input cache_line_data_t line, input int w);
        return 32'(line >> (32 * (CACHE_LINE_WORDS - 1 - w)));
    endfunction

    task automatic model();
        int hw;
        int f;
        logic rb;
        hw = -1;
        for (int w = 0; w < L1I_WAYS; w++)
            if (valids[w] && tags[w] == paddr.tag) hw = w;
        if (vaddr[1:0] != 2'b00)              f = 1;
        else if (!tlb_hit)                    f = 2;
        else if (!tlb_present)                f = 3;
        else if (tlb_sup && !sup_en[tid])     f = 4;
        else if (!tlb_exec)                   f = 5;
        else                                  f = 0;
        if (id_en) mem_m[id_way][id_set] = id_data;
        e_nmiss  = req && hw < 0 && f == 0 && (it_en != 0) && it_set == paddr.set_idx
                   && it_tag == paddr.tag && it_valid;
        e_miss   = req && hw < 0 && f == 0 && !e_nmiss;
        e_lru_en = req && hw >= 0 && f == 0;
        e_way    = hw;
        rb       = rb_en && rb_tid == tid;
        e_valid  = req && (hw >= 0 || f != 0) && !rb;
        e_flags  = (req && f != 0) ? (5'b10000 >> (f - 1)) : 5'b00000;
        e_instr  = (req && hw >= 0 && f == 0) ? word_of(mem_m[hw][paddr.set_idx], int'(paddr.offset[5:2])) : 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req = 0; paddr = '0; vaddr = '0; tid = '0;
        tlb_hit = 1; tlb_present = 1; tlb_exec = 1; tlb_sup = 0;
        for (int w = 0; w < L1I_WAYS; w++) tags[w] = '0;
        valids = '0; id_en = 0; id_way = '0; id_set = '0; id_data = '0;
        it_en = '0; it_set = '0; it_tag = '0; it_valid = 0;
        sup_en = '1; rb_en = 0; rb_tid = '0;
    endtask

    // Fetch setup: every way valid with distinct tags; hit_way < 0 means no way matches.
    task automatic setup_fetch(input int hit_way, input l1i_set_idx_t set, input logic [5:0] off,
                               input local_thread_idx_t t);
        set_idle();
        req = 1; tid = t;
        paddr.tag = l1i_tag_t'($urandom); paddr.set_idx = set; paddr.offset = off;
        vaddr = {$urandom_range(0, 32'hFFFF), 10'h0, off};
        for (int w = 0; w < L1I_WAYS; w++)
            tags[w] = (w == hit_way) ? paddr.tag : paddr.tag + l1i_tag_t'(w + 1);
        valids = '1;
    endtask

    task automatic rand_line(output cache_line_data_t line);
        for (int k = 0; k < CACHE_LINE_WORDS; k++) line[k*32 +: 32] = $urandom;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (ivalid !== 1'b0) $display("FAIL reset_valid got=%b want=0", ivalid); else n_pass++;
        n_total++; if ({f_al, f_tlb, f_pg, f_sup, f_ex} !== 5'b0) $display("FAIL reset_flags got=%b want=00000", {f_al, f_tlb, f_pg, f_sup, f_ex}); else n_pass++;
        n_total++; if (instr !== 32'h0 || opc !== 32'h0 || otid !== '0) $display("FAIL reset_data got instr=%h pc=%h tid=%0d want 0", instr, opc, otid); else n_pass++;
        n_total++; if ({lru_en, miss, nmiss} !== 3'b000) $display("FAIL reset_comb got=%b want=000", {lru_en, miss, nmiss}); else n_pass++;
        @(negedge clk); reset = 1;
        tick();
    endtask

    task automatic preload();
        for (int s = 0; s < L1I_SETS; s++)
            for (int w = 0; w < L1I_WAYS; w++) begin
                id_en = 1; id_way = l1i_way_idx_t'(w); id_set = l1i_set_idx_t'(s);
                rand_line(id_data);
                mem_m[w][s] = id_data;
                tick();
            end
        id_en = 0;
    endtask

    task automatic test_hit();
        setup_fetch(2, 6'd5, 6'h08, 2'd1);
        model();
        #1;
        n_total++; if (lru_en !== 1'b1 || lru_way !== 2'd2) $display("FAIL hit_lru got en=%b way=%0d want en=1 way=2", lru_en, lru_way); else n_pass++;
        n_total++; if (miss !== 1'b0) $display("FAIL hit_nomiss got=%b want=0", miss); else n_pass++;
        tick();
        n_total++; if (ivalid !== 1'b1) $display("FAIL hit_valid got=%b want=1", ivalid); else n_pass++;
        n_total++; if (instr !== word_of(mem_m[2][5], 2)) $display("FAIL hit_word2 got=%h want=%h", instr, word_of(mem_m[2][5], 2)); else n_pass++;
        n_total++; if (opc !== vaddr || otid !== 2'd1) $display("FAIL hit_pc got pc=%h tid=%0d want pc=%h tid=1", opc, otid, vaddr); else n_pass++;
    endtask

    task automatic test_miss();
        setup_fetch(-1, 6'd17, 6'h3C, 2'd3);
        model();
        #1;
        n_total++; if (miss !== 1'b1 || nmiss !== 1'b0) $display("FAIL miss_flag got miss=%b near=%b want 1/0", miss, nmiss); else n_pass++;
        n_total++; if (miss_paddr !== {paddr.tag, paddr.set_idx}) $display("FAIL miss_paddr got=%h want=%h", miss_paddr, {paddr.tag, paddr.set_idx}); else n_pass++;
        n_total++; if (miss_tid !== 2'd3) $display("FAIL miss_tid got=%0d want=3", miss_tid); else n_pass++;
        tick();
        n_total++; if (ivalid !== 1'b0) $display("FAIL miss_valid got=%b want=0", ivalid); else n_pass++;
    endtask

    task automatic test_near_miss();
        setup_fetch(-1, 6'd40, 6'h00, 2'd0);
        it_en = 4'b0001; it_set = paddr.set_idx; it_tag = paddr.tag; it_valid = 1;
        model();
        #1;
        n_total++; if (nmiss !== 1'b1 || miss !== 1'b0) $display("FAIL near_miss got near=%b miss=%b want 1/0", nmiss, miss); else n_pass++;
        it_valid = 0;
        #1;
        n_total++; if (nmiss !== 1'b0 || miss !== 1'b1) $display("FAIL near_miss_invalid got near=%b miss=%b want 0/1", nmiss, miss); else n_pass++;
        tick();
    endtask

    task automatic test_fault_priority();
        for (int f = 1; f <= 5; f++) begin
            setup_fetch(1, 6'd3, 6'h04, 2'd2);
            vaddr = (f == 1) ? 32'h0000_1002 : 32'h0000_1004;
            tlb_hit     = (f >= 3);
            tlb_present = (f >= 4) ? 1'b1 : 1'b0;
            tlb_sup     = 1'b1;
            sup_en[2]   = (f >= 5);
            tlb_exec    = 1'b0;
            model();
            #1;
            n_total++; if (lru_en !== 1'b0 || miss !== 1'b0) $display("FAIL fault%0d_comb got lru=%b miss=%b want 0/0", f, lru_en, miss); else n_pass++;
            tick();
            n_total++; if ({f_al, f_tlb, f_pg, f_sup, f_ex} !== e_flags) $display("FAIL fault%0d_flags got=%b want=%b", f, {f_al, f_tlb, f_pg, f_sup, f_ex}, e_flags); else n_pass++;
            n_total++; if (ivalid !== 1'b1 || instr !== 32'h0) $display("FAIL fault%0d_out got valid=%b instr=%h want 1/0", f, ivalid, instr); else n_pass++;
        end
    endtask

    task automatic test_rollback();
        setup_fetch(0, 6'd9, 6'h14, 2'd2);
        rb_en = 1; rb_tid = 2'd2;
        model();
        #1;
        n_total++; if (lru_en !== 1'b1) $display("FAIL rb_same_lru got=%b want=1", lru_en); else n_pass++;
        tick();
        n_total++; if (ivalid !== 1'b0) $display("FAIL rb_same_valid got=%b want=0", ivalid); else n_pass++;
        setup_fetch(3, 6'd9, 6'h14, 2'd2);
        rb_en = 1; rb_tid = 2'd1;
        model();
        tick();
        n_total++; if (ivalid !== 1'b1 || instr !== e_instr) $display("FAIL rb_other got valid=%b instr=%h want 1/%h", ivalid, instr, e_instr); else n_pass++;
    endtask

    task automatic test_read_during_write();
        setup_fetch(1, 6'd22, 6'h30, 2'd0);
        id_en = 1; id_way = 2'd1; id_set = 6'd22;
        rand_line(id_data);
        model();
        tick();
        n_total++; if (instr !== word_of(id_data, 12)) $display("FAIL rdw_word got=%h want=%h", instr, word_of(id_data, 12)); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_idle();
            req = ($urandom_range(0, 7) != 0);
            tid = local_thread_idx_t'($urandom);
            paddr = l1i_addr_t'($urandom);
            vaddr = $urandom;
            if ($urandom_range(0, 3) != 0) vaddr[1:0] = 2'b00;
            tlb_hit = ($urandom_range(0, 7) != 0); tlb_present = ($urandom_range(0, 7) != 0);
            tlb_exec = ($urandom_range(0, 7) != 0); tlb_sup = $urandom_range(0, 1);
            sup_en = THREADS_PER_CORE'($urandom);
            for (int w = 0; w < L1I_WAYS; w++) tags[w] = paddr.tag + l1i_tag_t'(w + 1);
            if ($urandom_range(0, 2) != 0) tags[$urandom_range(0, L1I_WAYS - 1)] = paddr.tag;
            valids = L1I_WAYS'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                id_en = 1; id_way = l1i_way_idx_t'($urandom);
                id_set = $urandom_range(0, 1) ? paddr.set_idx : l1i_set_idx_t'($urandom);
                rand_line(id_data);
            end
            if ($urandom_range(0, 2) == 0) begin
                it_en = L1I_WAYS'($urandom);
                it_set = $urandom_range(0, 3) != 0 ? paddr.set_idx : l1i_set_idx_t'($urandom);
                it_tag = $urandom_range(0, 3) != 0 ? paddr.tag : l1i_tag_t'($urandom);
                it_valid = $urandom_range(0, 1);
            end
            rb_en = ($urandom_range(0, 3) == 0); rb_tid = local_thread_idx_t'($urandom);
            model();
            #1;
            n_total++; if ({lru_en, miss, nmiss} !== {e_lru_en, e_miss, e_nmiss}) $display("FAIL rnd%0d_comb got lru/miss/near=%b want=%b", i, {lru_en, miss, nmiss}, {e_lru_en, e_miss, e_nmiss}); else n_pass++;
            if (e_lru_en) begin
                n_total++; if (int'(lru_way) != e_way) $display("FAIL rnd%0d_way got=%0d want=%0d", i, lru_way, e_way); else n_pass++;
            end
            if (e_miss) begin
                n_total++; if (miss_paddr !== {paddr.tag, paddr.set_idx} || miss_tid !== tid) $display("FAIL rnd%0d_misspa got=%h/%0d want=%h/%0d", i, miss_paddr, miss_tid, {paddr.tag, paddr.set_idx}, tid); else n_pass++;
            end
            tick();
            n_total++; if (ivalid !== e_valid || {f_al, f_tlb, f_pg, f_sup, f_ex} !== e_flags) $display("FAIL rnd%0d_reg got valid=%b flags=%b want %b/%b", i, ivalid, {f_al, f_tlb, f_pg, f_sup, f_ex}, e_valid, e_flags); else n_pass++;
            n_total++; if (opc !== vaddr || otid !== tid) $display("FAIL rnd%0d_pc got=%h/%0d want=%h/%0d", i, opc, otid, vaddr, tid); else n_pass++;
            if (e_valid) begin
                n_total++; if (instr !== e_instr) $display("FAIL rnd%0d_instr got=%h want=%h", i, instr, e_instr); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midop();
        setup_fetch(1, 6'd11, 6'h10, 2'd0);
        model();
        tick();
        n_total++; if (ivalid !== 1'b1) $display("FAIL midrst_pre got=%b want=1", ivalid); else n_pass++;
        reset = 0;
        #1;
        n_total++; if (ivalid !== 1'b0 || instr !== 32'h0 || opc !== 32'h0) $display("FAIL midrst_async got valid=%b instr=%h pc=%h want 0", ivalid, instr, opc); else n_pass++;
        set_idle();
        @(negedge clk); reset = 1;
        #1;
        n_total++; if (ivalid !== 1'b0) $display("FAIL midrst_release got=%b want=0", ivalid); else n_pass++;
        repeat (2) tick();
        n_total++; if (ivalid !== 1'b0 || {f_al, f_tlb, f_pg, f_sup, f_ex} !== 5'b0 || instr !== 32'h0) $display("FAIL midrst_idle got valid=%b flags=%b instr=%h want 0", ivalid, {f_al, f_tlb, f_pg, f_sup, f_ex}, instr); else n_pass++;
    endtask

    initial begin
        reset = 0;
        set_idle();
        test_reset();
        preload();
        test_hit();
        test_miss();
        test_near_miss();
        test_fault_priority();
        test_rollback();
        test_read_during_write();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
